// File: rtl/univ_shift_reg_seq_if.sv
// Control/data bundle for the universal shift register: the master drives commands, the slave returns contents and status.
// Latency and backpressure belong to the attached register; this file only groups the wires.
// No flow control here: busy from the slave tells the master when commands are ignored.
interface univ_shift_reg_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic [WIDTH-1:0] pdata;
    logic             sin_lsb;
    logic             sin_msb;
    logic [WIDTH-1:0] q;
    logic             sout_msb;
    logic             sout_lsb;
    logic             busy;
    logic             done;

    modport master (
        output en, start, mode, amount, pdata, sin_lsb, sin_msb,
        input  q, sout_msb, sout_lsb, busy, done
    );

    modport slave (
        input  en, start, mode, amount, pdata, sin_lsb, sin_msb,
        output q, sout_msb, sout_lsb, busy, done
    );
endinterface

// File: rtl/univ_shift_reg_seq.sv
// Universal shift register (hold/shift/rotate/ashr/load/clear) with a multi-step shift sequencer.
// Latency: en step and start edge take effect in 1 cycle; a sequenced run finishes amount edges after start, then a 1-cycle done.
// Backpressure: busy is high through RUN and DONE; start/en/mode/amount/pdata are ignored while busy.
module univ_shift_reg_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    univ_shift_reg_seq_if.slave bus
);

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_SHL  = 3'd1;
    localparam logic [2:0] M_SHR  = 3'd2;
    localparam logic [2:0] M_LOAD = 3'd3;
    localparam logic [2:0] M_ROL  = 3'd4;
    localparam logic [2:0] M_ROR  = 3'd5;
    localparam logic [2:0] M_ASR  = 3'd6;
    localparam logic [2:0] M_CLR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;

    function automatic logic [WIDTH-1:0] step_op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] pd,
        input logic             s_lsb,
        input logic             s_msb
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (m)
            M_HOLD: r = cur;
            M_SHL:  r = {cur[WIDTH-2:0], s_lsb};
            M_SHR:  r = {s_msb, cur[WIDTH-1:1]};
            M_LOAD: r = pd;
            M_ROL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROR:  r = {cur[0], cur[WIDTH-1:1]};
            M_ASR:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_CLR:  r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Hold, load and clear are single-shot ops: run them at the start edge instead of sequencing.
    function automatic logic is_oneshot(input logic [2:0] m);
        return (m == M_HOLD) || (m == M_LOAD) || (m == M_CLR);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    if (is_oneshot(bus.mode)) begin
                        q_d     = step_op(bus.mode, q_q, bus.pdata, bus.sin_lsb, bus.sin_msb);
                        cnt_d   = '0;
                        state_d = DONE;
                    end else if (bus.amount == '0) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = bus.amount;
                        state_d = RUN;
                    end
                end else if (bus.en) begin
                    q_d = step_op(bus.mode, q_q, bus.pdata, bus.sin_lsb, bus.sin_msb);
                end
            end
            RUN: begin
                q_d   = step_op(mode_q, q_q, bus.pdata, bus.sin_lsb, bus.sin_msb);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.sout_msb = q_q[WIDTH-1];
    assign bus.sout_lsb = q_q[0];
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Directed bench for univ_shift_reg_seq (WIDTH=8, CNT_W=4) with hand-computed expectations.
module tb_univ_shift_reg_seq;

    logic clk;
    logic rst_n;
    int   nchecks;
    int   nerrors;

    univ_shift_reg_seq_if #(.WIDTH(8), .CNT_W(4)) bus ();

    univ_shift_reg_seq #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        chk({tag, "_q"}, 32'(bus.q), 32'(eq));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(eb));
        chk({tag, "_done"}, 32'(bus.done), 32'(ed));
    endtask

    task automatic idle_inputs();
        bus.en = 1'b0; bus.start = 1'b0; bus.mode = 3'd0; bus.amount = 4'd0;
        bus.pdata = 8'h00; bus.sin_lsb = 1'b0; bus.sin_msb = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        bus.en = 1'b1; bus.mode = 3'd3; bus.pdata = v;
        tick();
        bus.en = 1'b0; bus.mode = 3'd0;
    endtask

    initial begin
        nchecks = 0;
        nerrors = 0;
        idle_inputs();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
        chk_st("rst_init", 8'h00, 1'b0, 1'b0);

        // asynchronous reset mid-cycle
        load(8'hFF);
        chk("pre_rst_q", 32'(bus.q), 32'h0000_00FF);
        chk("sout_msb", 32'(bus.sout_msb), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk_st("async_rst", 8'h00, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        tick(); tick();
        chk_st("rst_release", 8'h00, 1'b0, 1'b0);

        // single steps
        load(8'hA5);
        chk("step_load", 32'(bus.q), 32'h0000_00A5);
        bus.en = 1'b1; bus.mode = 3'd1; bus.sin_lsb = 1'b1;
        tick();
        chk("step_shl", 32'(bus.q), 32'h0000_004B);
        bus.mode = 3'd2; bus.sin_msb = 1'b0;
        tick();
        chk("step_shr", 32'(bus.q), 32'h0000_0025);
        chk("sout_lsb", 32'(bus.sout_lsb), 32'd1);
        bus.mode = 3'd6;
        tick();
        chk("step_asr_pos", 32'(bus.q), 32'h0000_0012);
        bus.mode = 3'd7;
        tick();
        chk_st("step_clr", 8'h00, 1'b0, 1'b0);
        idle_inputs();

        // sequenced rotate right by 3: A5 -> D2 -> 69 -> B4
        load(8'hA5);
        bus.start = 1'b1; bus.mode = 3'd5; bus.amount = 4'd3;
        tick();
        idle_inputs();
        chk_st("ror_start", 8'hA5, 1'b1, 1'b0);
        tick();
        chk_st("ror_s1", 8'hD2, 1'b1, 1'b0);
        tick();
        chk_st("ror_s2", 8'h69, 1'b1, 1'b0);
        tick();
        chk_st("ror_s3", 8'hB4, 1'b1, 1'b1);
        tick();
        chk_st("ror_idle", 8'hB4, 1'b0, 1'b0);

        // arithmetic right by 2: 90 -> C8 -> E4
        load(8'h90);
        bus.start = 1'b1; bus.mode = 3'd6; bus.amount = 4'd2;
        tick();
        idle_inputs();
        tick(); tick();
        chk_st("asr_done", 8'hE4, 1'b1, 1'b1);
        tick();

        // rotate left by WIDTH restores the value
        load(8'h3C);
        bus.start = 1'b1; bus.mode = 3'd4; bus.amount = 4'd8;
        tick();
        idle_inputs();
        for (int i = 0; i < 7; i++) tick();
        chk_st("rol8_s7", 8'h1E, 1'b1, 1'b0);
        tick();
        chk_st("rol8_done", 8'h3C, 1'b1, 1'b1);
        tick();

        // logical shift right by 10 from all-ones input fills fully from sin_msb
        load(8'h00);
        bus.start = 1'b1; bus.mode = 3'd2; bus.amount = 4'd10; bus.sin_msb = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk_st("shr10_done", 8'hFF, 1'b1, 1'b1);
        idle_inputs();
        tick();

        // amount 0 with shift mode: no change, done next cycle
        load(8'h3C);
        bus.start = 1'b1; bus.mode = 3'd1; bus.amount = 4'd0; bus.sin_lsb = 1'b1;
        tick();
        idle_inputs();
        chk_st("amt0_done", 8'h3C, 1'b1, 1'b1);
        tick();
        chk_st("amt0_idle", 8'h3C, 1'b0, 1'b0);

        // start wins over en: q unchanged at start edge
        bus.en = 1'b1; bus.start = 1'b1; bus.mode = 3'd2; bus.amount = 4'd1; bus.sin_msb = 1'b1;
        tick();
        bus.en = 1'b0; bus.start = 1'b0;
        chk_st("prio_start", 8'h3C, 1'b1, 1'b0);
        tick();
        chk_st("prio_done", 8'h9E, 1'b1, 1'b1);
        idle_inputs();
        tick();

        // en/start during RUN and start in DONE are ignored: 9E -> 3D -> 7A
        bus.start = 1'b1; bus.mode = 3'd4; bus.amount = 4'd2;
        tick();
        bus.en = 1'b1; bus.mode = 3'd3; bus.pdata = 8'h00; bus.amount = 4'd5;
        tick();
        chk_st("ign_s1", 8'h3D, 1'b1, 1'b0);
        tick();
        chk_st("ign_done", 8'h7A, 1'b1, 1'b1);
        tick();
        idle_inputs();
        chk_st("ign_idle", 8'h7A, 1'b0, 1'b0);
        tick();
        chk_st("ign_stay", 8'h7A, 1'b0, 1'b0);

        // reset mid-run: 81 -> 03 -> 06 -> 0C -> 18
        load(8'h81);
        bus.start = 1'b1; bus.mode = 3'd4; bus.amount = 4'd10;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        chk_st("mid_s4", 8'h18, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_st("mid_rst", 8'h00, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        tick(); tick();
        chk_st("mid_after", 8'h00, 1'b0, 1'b0);

        // sequencer works normally afterwards
        bus.start = 1'b1; bus.mode = 3'd3; bus.pdata = 8'hA5;
        tick();
        idle_inputs();
        chk_st("post_load", 8'hA5, 1'b1, 1'b1);
        tick();
        bus.start = 1'b1; bus.mode = 3'd4; bus.amount = 4'd1;
        tick();
        idle_inputs();
        tick();
        chk_st("post_rol", 8'h4B, 1'b1, 1'b1);
        tick();
        chk_st("post_idle", 8'h4B, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
